mf8_reg_dbg: RTL and testbench

- Arbiter and sequencer that shares the mf8 two-read/one-write register file between the CPU core and a debug port.
- Sits between the core datapath and the register file instance; all core register-file signals pass through it.
- Grants single-byte debug reads and writes by stalling the core, draining any in-flight core write, and restoring the core read address before the core is released.
- The register file samples the write address one cycle before Wr/Data and has one-cycle registered read with write bypass. This block sequences around that timing.

---
 rtl/mf8_reg_dbg.sv | 127 ++++++++++++
 tb/tb_mf8_reg_dbg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mf8_reg_dbg.sv
// mf8 register-file arbiter: shares the 2R/1W register file between the
// core datapath and a single-byte debug port. A debug access stalls the
// core for exactly three cycles (DRAIN, ACC, DONE). After each access a
// holdoff counter guarantees the core a minimum run of unstalled cycles
// before the next grant.
module mf8_reg_dbg #(
  parameter int unsigned MIN_CORE_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  // core side
  input  logic       Core_Wr,
  input  logic [4:0] Core_Rd_Addr,
  input  logic [4:0] Core_Rr_Addr,
  input  logic [7:0] Core_Data_In,
  output logic       Core_Stall,
  // debug side
  input  logic       Dbg_Req,
  input  logic       Dbg_We,
  input  logic [4:0] Dbg_Addr,
  input  logic [7:0] Dbg_WData,
  output logic       Dbg_Ack,
  output logic [7:0] Dbg_RData,
  // register file side
  output logic       RF_Wr,
  output logic [4:0] RF_Rd_Addr,
  output logic [4:0] RF_Rr_Addr,
  output logic [7:0] RF_Data_In,
  input  logic [7:0] RF_Rd_Data
);

  // Reject illegal holdoff lengths at elaboration time.
  generate
    if (MIN_CORE_CYCLES < 1 || MIN_CORE_CYCLES > 15) begin : g_bad_min_core_cycles
      $error("mf8_reg_dbg: MIN_CORE_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] HOLDOFF_LOAD = 4'(MIN_CORE_CYCLES);

  // HOLD is not a separate encoding: it is IDLE with a nonzero holdoff.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ACC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] holdoff_reg, holdoff_next;
  logic [7:0] rdata_reg;
  logic       grant;

  // The IDLE cycle that grants a request still runs the core, so it counts
  // as one of the guaranteed core cycles: a grant is allowed once this
  // cycle's decrement brings the counter to zero.
  assign grant = (state_reg == IDLE) && Dbg_Req && (holdoff_reg <= 4'd1);

  // State and holdoff registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= IDLE;
      holdoff_reg <= 4'd0;
    end else begin
      state_reg   <= state_next;
      holdoff_reg <= holdoff_next;
    end
  end

  // Next-state and holdoff counter logic.
  always_comb begin
    state_next   = state_reg;
    holdoff_next = holdoff_reg;
    case (state_reg)
      IDLE: begin
        if (holdoff_reg != 4'd0) holdoff_next = holdoff_reg - 4'd1;
        if (grant) state_next = DRAIN;
      end
      DRAIN: state_next = ACC;
      ACC:   state_next = DONE;
      DONE: begin
        holdoff_next = HOLDOFF_LOAD;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Register-file port muxing by state.
  always_comb begin
    RF_Wr      = Core_Wr;
    RF_Rd_Addr = Core_Rd_Addr;
    RF_Data_In = Core_Data_In;
    case (state_reg)
      // Finish the core write whose address went out in the last IDLE
      // cycle, while pointing the read/write-address latch at the target.
      DRAIN: begin
        RF_Rd_Addr = Dbg_Addr;
      end
      ACC: begin
        RF_Wr      = Dbg_We;
        RF_Rd_Addr = Dbg_Addr;
        RF_Data_In = Dbg_WData;
      end
      // Re-prime the core read and the write-address latch.
      DONE: begin
        RF_Wr = 1'b0;
      end
      default: ;
    endcase
  end

  // Capture debug read data at the end of ACC; held until the next read.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rdata_reg <= 8'h00;
    end else if (state_reg == ACC && !Dbg_We) begin
      rdata_reg <= RF_Rd_Data;
    end
  end

  assign Core_Stall = (state_reg != IDLE);
  assign Dbg_Ack    = (state_reg == DONE);
  assign Dbg_RData  = rdata_reg;
  assign RF_Rr_Addr = Core_Rr_Addr;

endmodule

// File: tb/tb_mf8_reg_dbg.sv
// Testbench for mf8_reg_dbg: includes a behavioural mf8 register file
// (write address sampled one cycle early, registered read with bypass) and
// a transaction-level reference of register contents and debug read data.
module tb_mf8_reg_dbg;

  localparam int MIN = 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Core_Wr;
  logic [4:0] Core_Rd_Addr;
  logic [4:0] Core_Rr_Addr;
  logic [7:0] Core_Data_In;
  logic       Core_Stall;
  logic       Dbg_Req;
  logic       Dbg_We;
  logic [4:0] Dbg_Addr;
  logic [7:0] Dbg_WData;
  logic       Dbg_Ack;
  logic [7:0] Dbg_RData;
  logic       RF_Wr;
  logic [4:0] RF_Rd_Addr;
  logic [4:0] RF_Rr_Addr;
  logic [7:0] RF_Data_In;
  logic [7:0] RF_Rd_Data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] ref_mem [32];
  logic [7:0] ref_rdata;

  always #5 Clk = ~Clk;

  mf8_reg_dbg #(.MIN_CORE_CYCLES(MIN)) dut (
    .Clk(Clk), .Reset(Reset),
    .Core_Wr(Core_Wr), .Core_Rd_Addr(Core_Rd_Addr), .Core_Rr_Addr(Core_Rr_Addr),
    .Core_Data_In(Core_Data_In), .Core_Stall(Core_Stall),
    .Dbg_Req(Dbg_Req), .Dbg_We(Dbg_We), .Dbg_Addr(Dbg_Addr), .Dbg_WData(Dbg_WData),
    .Dbg_Ack(Dbg_Ack), .Dbg_RData(Dbg_RData),
    .RF_Wr(RF_Wr), .RF_Rd_Addr(RF_Rd_Addr), .RF_Rr_Addr(RF_Rr_Addr),
    .RF_Data_In(RF_Data_In), .RF_Rd_Data(RF_Rd_Data)
  );

  // Register file environment model.
  logic [7:0] rf_mem [32];
  logic [4:0] rf_wa;
  logic [7:0] rf_q;
  always @(posedge Clk) begin
    rf_wa <= RF_Rd_Addr;
    if (RF_Wr) rf_mem[rf_wa] <= RF_Data_In;
    rf_q <= (RF_Wr && rf_wa == RF_Rd_Addr) ? RF_Data_In : rf_mem[RF_Rd_Addr];
  end
  assign RF_Rd_Data = rf_q;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic core_write(input logic [4:0] a, input logic [7:0] d);
    Core_Rd_Addr = a;
    Core_Wr      = 1'b0;
    tick;
    Core_Wr      = 1'b1;
    Core_Data_In = d;
    tick;
    Core_Wr      = 1'b0;
    ref_mem[a]   = d;
    $display("core_write r%0d <= %h", a, d);
  endtask

  task automatic core_read(input logic [4:0] a, output logic [7:0] q);
    Core_Rd_Addr = a;
    Core_Rr_Addr = 5'($urandom);
    #1;
    check("rr_passthru", {11'd0, RF_Rr_Addr}, {11'd0, Core_Rr_Addr});
    tick;
    q = RF_Rd_Data;
    check("core_read", {8'd0, q}, {8'd0, ref_mem[a]});
    $display("core_read  r%0d -> %h (ref %h)", a, q, ref_mem[a]);
  endtask

  // One debug access, optionally with a core write whose address is issued
  // in the grant cycle and whose data lands during the stall.
  task automatic dbg_access(input logic we, input logic [4:0] a, input logic [7:0] wd,
                            input logic cw, input logic [4:0] ca, input logic [7:0] cd);
    Dbg_Req = 1'b0;
    Core_Wr = 1'b0;
    tick;
    tick;
    Core_Rd_Addr = ca;
    Dbg_Req      = 1'b1;
    Dbg_We       = we;
    Dbg_Addr     = a;
    Dbg_WData    = wd;
    #1;
    check("grant_stall", {15'd0, Core_Stall}, 16'd0);
    tick; // DRAIN
    check("drain_stall", {15'd0, Core_Stall}, 16'd1);
    check("drain_ack", {15'd0, Dbg_Ack}, 16'd0);
    check("drain_rdaddr", {11'd0, RF_Rd_Addr}, {11'd0, a});
    if (cw) begin
      Core_Wr      = 1'b1;
      Core_Data_In = cd;
      #1;
      check("drain_core_wr", {15'd0, RF_Wr}, 16'd1);
    end
    tick; // ACC
    Core_Wr = 1'b0;
    #1;
    check("acc_stall", {15'd0, Core_Stall}, 16'd1);
    check("acc_wr", {15'd0, RF_Wr}, {15'd0, we});
    check("acc_rdaddr", {11'd0, RF_Rd_Addr}, {11'd0, a});
    if (we) check("acc_wdata", {8'd0, RF_Data_In}, {8'd0, wd});
    tick; // DONE
    if (cw) ref_mem[ca] = cd;
    if (we) ref_mem[a] = wd;
    else ref_rdata = ref_mem[a];
    check("done_ack", {15'd0, Dbg_Ack}, 16'd1);
    check("done_stall", {15'd0, Core_Stall}, 16'd1);
    check("done_wr", {15'd0, RF_Wr}, 16'd0);
    check("done_reprime", {11'd0, RF_Rd_Addr}, {11'd0, ca});
    check("done_rdata", {8'd0, Dbg_RData}, {8'd0, ref_rdata});
    Dbg_Req = 1'b0;
    tick; // back to core
    check("post_ack", {15'd0, Dbg_Ack}, 16'd0);
    check("post_stall", {15'd0, Core_Stall}, 16'd0);
    check("rdata_held", {8'd0, Dbg_RData}, {8'd0, ref_rdata});
    $display("dbg_%s r%0d wd=%h rdata=%h cw=%0d r%0d<=%h", we ? "write" : "read ",
             a, wd, Dbg_RData, cw, ca, cd);
  endtask

  initial begin
    logic [7:0] q, lo, hi;
    int k;
    Reset = 1'b1; Core_Wr = 1'b0; Core_Rd_Addr = '0; Core_Rr_Addr = '0;
    Core_Data_In = '0; Dbg_Req = 1'b0; Dbg_We = 1'b0; Dbg_Addr = '0; Dbg_WData = '0;
    ref_rdata = 8'h00;
    tick;
    tick;
    check("rst_stall", {15'd0, Core_Stall}, 16'd0);
    check("rst_ack", {15'd0, Dbg_Ack}, 16'd0);
    check("rst_rdata", {8'd0, Dbg_RData}, 16'd0);
    Reset = 1'b0;
    tick;
    check("idle_stall", {15'd0, Core_Stall}, 16'd0);

    // Preload every register through the core path.
    for (int i = 0; i < 32; i++) core_write(5'(i), 8'($urandom));

    // Debug write r5, then core sees it.
    dbg_access(1'b1, 5'd5, 8'hA7, 1'b0, 5'd0, 8'h00);
    core_read(5'd5, q);
    // Debug read of a preloaded register.
    core_write(5'd12, 8'h3C);
    dbg_access(1'b0, 5'd12, 8'h00, 1'b0, 5'd12, 8'h00);
    check("read_3c", {8'd0, Dbg_RData}, 16'h003C);
    // Core write in flight at grant; debug read returns it via bypass.
    dbg_access(1'b0, 5'd12, 8'h00, 1'b1, 5'd12, 8'h55);
    check("bypass_55", {8'd0, Dbg_RData}, 16'h0055);
    // Z register built from two debug writes.
    dbg_access(1'b1, 5'd30, 8'h34, 1'b0, 5'd0, 8'h00);
    dbg_access(1'b1, 5'd31, 8'h12, 1'b0, 5'd0, 8'h00);
    core_read(5'd30, lo);
    core_read(5'd31, hi);
    check("z_reg", {hi, lo}, 16'h1234);

    // Continuous request: stall pattern repeats every 3 + MIN cycles.
    Dbg_Req = 1'b0;
    tick; tick; tick;
    Dbg_Req = 1'b1; Dbg_We = 1'b0; Dbg_Addr = 5'd7;
    for (int i = 1; i <= 10; i++) begin
      tick;
      k = (i - 1) % (3 + MIN);
      check("cont_stall", {15'd0, Core_Stall}, {15'd0, (k < 3)});
      check("cont_ack", {15'd0, Dbg_Ack}, {15'd0, (k == 2)});
      $display("cont cycle %0d stall=%0d ack=%0d", i, Core_Stall, Dbg_Ack);
    end
    Dbg_Req = 1'b0;
    ref_rdata = ref_mem[7];
    tick; tick; tick; tick; tick;
    check("cont_rdata", {8'd0, Dbg_RData}, {8'd0, ref_rdata});
    check("cont_idle", {15'd0, Core_Stall}, 16'd0);

    // Reset during ACC of a debug write: no ack, write not committed.
    tick; tick;
    Dbg_Req = 1'b1; Dbg_We = 1'b1; Dbg_Addr = 5'd9; Dbg_WData = ~ref_mem[9];
    tick; // DRAIN
    tick; // ACC
    Reset = 1'b1;
    Dbg_Req = 1'b0;
    #1;
    check("mid_rst_stall", {15'd0, Core_Stall}, 16'd0);
    check("mid_rst_ack", {15'd0, Dbg_Ack}, 16'd0);
    check("mid_rst_rdata", {8'd0, Dbg_RData}, 16'd0);
    ref_rdata = 8'h00;
    tick;
    Reset = 1'b0;
    tick;
    core_read(5'd9, q);
    $display("reset during ACC: r9=%h", q);

    // Randomised mix of core and debug traffic.
    for (int n = 0; n < 60; n++) begin
      logic [4:0] a, ca;
      ca = 5'($urandom);
      a  = ($urandom_range(0, 1) == 1) ? ca : 5'($urandom);
      case ($urandom_range(0, 3))
        0: core_write(a, 8'($urandom));
        1: core_read(a, q);
        default: dbg_access(1'($urandom), a, 8'($urandom), 1'($urandom), ca, 8'($urandom));
      endcase
    end
    for (int i = 0; i < 32; i++) core_read(5'(i), q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
